// File: rtl/buffer_pkg.sv
// Shared sizing and types for the packet byte buffer.
// Constants and typedefs only; no logic, so no latency or backpressure.
package buffer_pkg;
    localparam int BUF_DEPTH = 64;
    localparam int BUF_WIDTH = 8;

    typedef logic [6:0] occ_t;
    typedef logic [5:0] ptr_t;
endpackage

// File: rtl/buffer_ptr_ctrl.sv
// Pointer, occupancy and accept control for the byte buffer.
// Accepts are combinational; pointers, occupancy and error pulses update at the next edge.
// A write at full and a read at empty are dropped and flagged; flush overrides everything.
module buffer_ptr_ctrl
    import buffer_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic          wr_accept,
    output logic          rd_accept,
    output logic [AW-1:0] wptr,
    output logic [AW-1:0] rptr,
    output logic [AW:0]   occupancy,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          underflow
);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   occ_q, occ_d;
    logic          overflow_q, underflow_q;

    assign full  = (occ_q == OCC_FULL);
    assign empty = (occ_q == '0);

    always_comb begin
        wr_accept = wr_en & ~full & ~flush;
        rd_accept = rd_en & ~empty & ~flush;
        occ_d     = occ_q;
        if (wr_accept && !rd_accept) begin
            occ_d = occ_q + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            occ_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            occ_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_accept) wptr_q <= wptr_q + 1'b1;
            if (rd_accept) rptr_q <= rptr_q + 1'b1;
            occ_q       <= occ_d;
            // Drops are judged on pre-edge state, so a same-cycle opposite access never rescues them.
            overflow_q  <= wr_en & full;
            underflow_q <= rd_en & empty;
        end
    end

    assign wptr      = wptr_q;
    assign rptr      = rptr_q;
    assign occupancy = occ_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: rtl/data_buffer_64.sv
// Single-packet byte FIFO between bus-side producer and packet-side consumer.
// Read data registered one cycle after an accepted read; written bytes readable the next cycle.
// No stall: writes at full and reads at empty are dropped and pulse overflow/underflow.
module data_buffer_64
    import buffer_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH,
    parameter int WIDTH = BUF_WIDTH
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   wr_accept,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [AW-1:0]    wptr, rptr;
    logic             rd_accept;

    buffer_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (flush),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wr_accept (wr_accept),
        .rd_accept (rd_accept),
        .wptr      (wptr),
        .rptr      (rptr),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Storage is left unreset; only bytes behind the write pointer are ever read.
    always_ff @(posedge clk) begin
        if (wr_accept) mem_q[wptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_data_q <= '0;
        end else if (rd_accept) begin
            rd_data_q <= mem_q[rptr];
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: tb/tb_data_buffer_64.sv
// Directed bench for data_buffer_64: reset, fill/drain, drops, simultaneous access, flush, wrap.
module tb_data_buffer_64;
    import buffer_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       wr_accept;
    occ_t       occupancy;
    logic       full, empty, overflow, underflow;

    int n_cmp = 0;
    int n_bad = 0;

    data_buffer_64 dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .wr_accept (wr_accept),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic f, input logic w, input logic [7:0] d, input logic r);
        flush = f; wr_en = w; wr_data = d; rd_en = r;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        step();
        n_cmp++; if (occupancy !== 7'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_bad++; $display("FAIL reset_init: occ=%0d empty=%b full=%b want 0/1/0", occupancy, empty, full);
        end
        n_cmp++; if (rd_data !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_bad++; $display("FAIL reset_init_out: rd=%h ov=%b un=%b want 00/0/0", rd_data, overflow, underflow);
        end
        n_rst = 1'b1;
        step();
        for (int i = 0; i < 18; i++) begin
            drive(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0); step();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1); step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (occupancy !== 7'd17 || rd_data !== 8'hC0) begin
            n_bad++; $display("FAIL pre_reset: occ=%0d rd=%h want 17/c0", occupancy, rd_data);
        end
        #2 n_rst = 1'b0;
        #1;
        n_cmp++; if (occupancy !== 7'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid: occ=%0d empty=%b full=%b want 0/1/0", occupancy, empty, full);
        end
        n_cmp++; if (rd_data !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_out: rd=%h ov=%b un=%b want 00/0/0", rd_data, overflow, underflow);
        end
        @(posedge clk); #1 n_rst = 1'b1;
        step();
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b0);
            #1;
            n_cmp++; if (wr_accept !== 1'b1) begin
                n_bad++; $display("FAIL fill_accept[%0d]: got %b want 1", i, wr_accept);
            end
            step();
        end
        n_cmp++; if (occupancy !== 7'd64 || full !== 1'b1 || empty !== 1'b0) begin
            n_bad++; $display("FAIL fill_full: occ=%0d full=%b empty=%b want 64/1/0", occupancy, full, empty);
        end
        drive(1'b0, 1'b1, 8'hFF, 1'b0);
        #1;
        n_cmp++; if (wr_accept !== 1'b0) begin
            n_bad++; $display("FAIL ovf_accept: got %b want 0", wr_accept);
        end
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (overflow !== 1'b1 || occupancy !== 7'd64) begin
            n_bad++; $display("FAIL ovf_pulse: ov=%b occ=%0d want 1/64", overflow, occupancy);
        end
        step();
        n_cmp++; if (overflow !== 1'b0) begin
            n_bad++; $display("FAIL ovf_clear: got %b want 0", overflow);
        end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1); step();
            n_cmp++; if (rd_data !== 8'(i)) begin
                n_bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, rd_data, 8'(i));
            end
        end
        n_cmp++; if (empty !== 1'b1 || occupancy !== 7'd0) begin
            n_bad++; $display("FAIL drain_empty: empty=%b occ=%0d want 1/0", empty, occupancy);
        end
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (underflow !== 1'b1 || rd_data !== 8'h3F) begin
            n_bad++; $display("FAIL unf_pulse: un=%b rd=%h want 1/3f", underflow, rd_data);
        end
        step();
        n_cmp++; if (underflow !== 1'b0 || rd_data !== 8'h3F) begin
            n_bad++; $display("FAIL unf_clear: un=%b rd=%h want 0/3f", underflow, rd_data);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 8'(8'h10 + i), 1'b0); step();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 8'(8'h80 + i), 1'b1); step();
            n_cmp++; if (rd_data !== 8'(8'h10 + i) || occupancy !== 7'd10) begin
                n_bad++; $display("FAIL both_mid[%0d]: rd=%h occ=%0d want %h/10", i, rd_data, occupancy, 8'(8'h10 + i));
            end
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1); step();
            n_cmp++; if (rd_data !== ((i < 5) ? 8'(8'h15 + i) : 8'(8'h80 + i - 5))) begin
                n_bad++; $display("FAIL both_order[%0d]: got %h", i, rd_data);
            end
        end
        drive(1'b0, 1'b1, 8'h55, 1'b1); step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (underflow !== 1'b1 || occupancy !== 7'd1 || rd_data !== 8'h84) begin
            n_bad++; $display("FAIL both_empty: un=%b occ=%0d rd=%h want 1/1/84", underflow, occupancy, rd_data);
        end
        for (int i = 0; i < 63; i++) begin
            drive(1'b0, 1'b1, 8'(8'h90 + i), 1'b0); step();
        end
        n_cmp++; if (full !== 1'b1) begin
            n_bad++; $display("FAIL both_prefull: full=%b want 1", full);
        end
        drive(1'b0, 1'b1, 8'hEE, 1'b1);
        #1;
        n_cmp++; if (wr_accept !== 1'b0) begin
            n_bad++; $display("FAIL both_full_accept: got %b want 0", wr_accept);
        end
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (overflow !== 1'b1 || occupancy !== 7'd63 || rd_data !== 8'h55) begin
            n_bad++; $display("FAIL both_full: ov=%b occ=%0d rd=%h want 1/63/55", overflow, occupancy, rd_data);
        end
        step();
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b0, 8'h00, 1'b0); step();
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, 1'b1, 8'(8'h20 + i), 1'b0); step();
        end
        n_cmp++; if (occupancy !== 7'd30) begin
            n_bad++; $display("FAIL flush_pre: occ=%0d want 30", occupancy);
        end
        drive(1'b1, 1'b1, 8'h77, 1'b1);
        #1;
        n_cmp++; if (wr_accept !== 1'b0) begin
            n_bad++; $display("FAIL flush_accept: got %b want 0", wr_accept);
        end
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (occupancy !== 7'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_bad++; $display("FAIL flush_state: occ=%0d empty=%b ov=%b un=%b want 0/1/0/0", occupancy, empty, overflow, underflow);
        end
        n_cmp++; if (rd_data !== 8'h55) begin
            n_bad++; $display("FAIL flush_hold: got %h want 55", rd_data);
        end
        drive(1'b0, 1'b1, 8'hA5, 1'b0); step();
        drive(1'b0, 1'b0, 8'h00, 1'b1); step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (rd_data !== 8'hA5 || empty !== 1'b1) begin
            n_bad++; $display("FAIL flush_after: rd=%h empty=%b want a5/1", rd_data, empty);
        end
    endtask

    task automatic test_wrap();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 40; i++) begin
                drive(1'b0, 1'b1, 8'(pass * 64 + i), 1'b0); step();
            end
            n_cmp++; if (occupancy !== 7'd40) begin
                n_bad++; $display("FAIL wrap_occ[%0d]: got %0d want 40", pass, occupancy);
            end
            for (int i = 0; i < 40; i++) begin
                drive(1'b0, 1'b0, 8'h00, 1'b1); step();
                n_cmp++; if (rd_data !== 8'(pass * 64 + i)) begin
                    n_bad++; $display("FAIL wrap_data[%0d][%0d]: got %h want %h", pass, i, rd_data, 8'(pass * 64 + i));
                end
            end
            drive(1'b0, 1'b0, 8'h00, 1'b0);
            n_cmp++; if (empty !== 1'b1) begin
                n_bad++; $display("FAIL wrap_empty[%0d]: got %b want 1", pass, empty);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_simultaneous();
        test_flush();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_buffer_64.md
# data_buffer_64

Single-clock 64-entry × 8-bit byte FIFO that holds one USB packet's payload between the bus-side producer and the packet-side consumer. It accepts byte writes and byte reads, reports occupancy, full and empty, and flags dropped accesses. It supports a one-cycle flush that discards the contents. Its write-accept strobe and flush drive the downstream 64-byte completion counter directly.

## Interface
Parameters:
- DEPTH, 64, number of byte entries (power of two)
- WIDTH, 8, bits per entry

Ports:
- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  asynchronous active-low reset
- flush  input  1  discard all contents this cycle
- wr_en  input  1  write request
- wr_data  input  WIDTH  byte to store
- rd_en  input  1  read request
- rd_data  output  WIDTH  registered read data
- wr_accept  output  1  write accepted this cycle (combinational), feeds downstream counter enable
- occupancy  output  $clog2(DEPTH)+1  bytes stored, 0..DEPTH
- full  output  1  occupancy == DEPTH
- empty  output  1  occupancy == 0
- overflow  output  1  one-cycle pulse, write dropped
- underflow  output  1  one-cycle pulse, read dropped

## Operation
- Storage is a DEPTH×WIDTH register array. Write and read pointers are $clog2(DEPTH) bits, wrapping 63→0. Occupancy is tracked explicitly.
- Accept rules are evaluated on the current (pre-edge) occupancy:
  - wr_accept = wr_en & !full & !flush
  - rd_accept = rd_en & !empty & !flush
- At full, a write is dropped even when a read is accepted in the same cycle. At empty, a read is dropped even when a write is accepted in the same cycle.
- Accepted write: mem[wptr] ← wr_data; wptr +1.
- Accepted read: rd_data ← mem[rptr]; rptr +1.
- Occupancy next value:
  - +1 for write-only accept
  - −1 for read-only accept
  - unchanged for both accepted or neither
  - occupancy never leaves 0..DEPTH
- Dropped accesses:
  - Dropped write (wr_en & full & !flush): overflow = 1 next cycle for one cycle, state unchanged.
  - Dropped read (rd_en & empty & !flush): underflow = 1 next cycle for one cycle; rd_data holds its previous value.
- flush has priority over everything:
  - wptr, rptr and occupancy ← 0; rd_data holds its value.
  - Concurrent wr_en/rd_en are ignored and raise no error pulses.
  - mem contents are not cleared.
- Reset (asynchronous, any time including mid-packet): pointers 0, occupancy 0, rd_data 0, overflow 0, underflow 0. full = 0, empty = 1 after reset. mem contents are don't-care.

## Timing
- Write to visibility: a byte written at edge N is readable with rd_en high in the cycle after N. rd_data is valid after the following edge.
- Read latency is 1 cycle: rd_en sampled at edge N, rd_data valid after edge N.
- occupancy, full and empty are registered-derived and update at the same edge as the accepted access.
- wr_accept is combinational from wr_en, full and flush in the same cycle. The downstream counter sees it before the edge that stores the byte.
- Back-to-back reads and writes every cycle are sustained at full throughput, with no bubbles.

## Structure
- Shared package buffer_pkg holds:
  - BUF_DEPTH = 64 and BUF_WIDTH = 8
  - typedef occ_t, logic [6:0]
  - typedef ptr_t, logic [5:0]
- One sub-module is natural: buffer_ptr_ctrl, which contains both pointers, occupancy, full/empty, the accept logic and the error pulses. The top level holds the memory array and rd_data register.

## Test plan
- Reset: assert n_rst=0 mid-stream at occupancy 17 → immediately occupancy=0, empty=1, full=0, rd_data=0x00, overflow=underflow=0.
- Fill and overflow:
  - Write 0x00..0x3F on 64 consecutive cycles → occupancy=64, full=1, wr_accept high for all 64.
  - 65th write of 0xFF → wr_accept=0, overflow pulses one cycle, occupancy stays 64.
- Drain and underflow:
  - Read 64 consecutive cycles → rd_data sequence 0x00..0x3F, empty=1.
  - Extra read → underflow pulses, rd_data stays 0x3F.
- Simultaneous access:
  - At occupancy 10, wr_en=rd_en=1 for 5 cycles → occupancy stays 10 and data order is preserved.
  - At empty with both high → write accepted, underflow pulses, occupancy=1.
  - At full with both high → read accepted, overflow pulses, occupancy=63.
- Flush: at occupancy 30, assert flush with wr_en=rd_en=1 → next cycle occupancy=0, empty=1, no error pulses, wr_accept=0; the next write of 0xA5 reads back as 0xA5.
- Wrap-around: write 40, read 40, write 40 bytes (0x40..0x67), read 40 → pointers wrap past 63, rd_data returns 0x40..0x67 in order.
